dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Two-requester arbiter sharing the single-port data memory between two sources:
  - Port 0: the pipeline memory stage.
  - Port 1: the loader/debug port, used for program data preload and result dump.
- Sits between both requesters and the data memory.
- Drives the memory's address, write data and write-enable.
- Routes the memory's registered read data, which arrives one cycle after the address, back to whichever port issued the read.
- Port 0 has fixed priority, but a bounded-wait counter guarantees port 1 progress.

Parameters:
- ADDR_BITS, 10: number of word-address bits forwarded to the memory; matches the memory depth 2^ADDR_BITS.
- MAX_WAIT, 4: consecutive cycles port 1 may be refused before it is forced ahead of port 0. Legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-low reset; sampled on rising edge of clk.
- p0_req  input  1  port 0 access request.
- p0_we  input  1  port 0 write (1) / read (0).
- p0_addr  input  32  port 0 word address.
- p0_wdata  input  32  port 0 write data.
- p0_gnt  output  1  port 0 request accepted this cycle (combinational).
- p0_rvalid  output  1  port 0 read data valid.
- p0_rdata  output  32  port 0 read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
- mem_addr  output  ADDR_BITS  address to memory.
- mem_wdata  output  32  write data to memory.
- mem_we  output  1  write enable to memory.
- mem_rdata  input  32  registered memory read data; valid the cycle after the address.
- p1_wait_cnt  output  4  current port 1 starvation count, for debug.

Behaviour:
- Reset (rst == 0 at a rising edge):
  - p1_wait_cnt = 0, rd_pending = 0, rd_owner = 0.
  - p0_rvalid = p1_rvalid = 0.
  - While rst is low: p0_gnt = p1_gnt = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - A read accepted in the cycle before reset asserts produces no rvalid.
- Arbitration (combinational, every cycle):
  - force1 = p1_req && (p1_wait_cnt >= MAX_WAIT).
  - If force1: p1_gnt = 1, p0_gnt = 0.
  - Else if p0_req: p0_gnt = 1.
  - Else if p1_req: p1_gnt = 1.
  - At most one grant per cycle. A grant is only ever asserted while the matching req is high.
- Memory drive:
  - Granted port n: mem_addr = pn_addr[ADDR_BITS-1:0]; upper address bits are ignored. mem_wdata = pn_wdata, mem_we = pn_we.
  - No grant: mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Starvation counter (registered):
  - If p1_req && !p1_gnt: increment, saturating at 15.
  - Else: clear to 0. This covers both p1_gnt high and p1_req low.
- Read return:
  - On a rising edge with a granted read (gnt && !we): rd_pending <= 1, rd_owner <= granted port. Otherwise rd_pending <= 0.
  - pN_rvalid = rd_pending && (rd_owner == N); registered, one-cycle pulse.
  - p0_rdata = p1_rdata = mem_rdata, unconditionally. Data is qualified only by rvalid.
  - Read latency: request accepted in cycle T -> rvalid and data in cycle T+1.
  - Back-to-back reads from the same or alternating ports are accepted every cycle, with no bubble.
- Writes:
  - Committed at the rising edge ending the grant cycle.
  - No rvalid for writes.
  - A read of the same address granted in the next cycle returns the new data.
- Requester rule: a requester holds req/we/addr/wdata stable until it sees gnt. The arbiter does not latch un-granted requests.
- No internal queue; the arbiter adds zero cycles beyond the memory's own latency.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, both req=0 -> all gnt/rvalid = 0, mem_we = 0, p1_wait_cnt = 0.
- Single read: mem[5] preloaded with 0x0000002A; p0 read addr 5 for 1 cycle -> p0_gnt=1 that cycle; p0_rvalid=1 next cycle with p0_rdata=0x2A; p1_rvalid stays 0.
- Priority and starvation: p0 and p1 both request continuously, MAX_WAIT=4 -> p0 granted 4 cycles; p1_wait_cnt 0,1,2,3,4; cycle 5 p1_gnt=1, p0_gnt=0; counter back to 0; pattern repeats as 4:1.
- Write-then-read across ports: p1 writes 0xDEADBEEF to addr 0x3FF; next cycle p0 reads addr 0x7FF (aliases to 0x3FF with ADDR_BITS=10) -> p0_rdata=0xDEADBEEF one cycle later.
- Back-to-back alternating reads: p0 read addr 1 (=11), then p1 read addr 2 (=22), on consecutive cycles -> p0_rvalid with 11, then p1_rvalid with 22, on consecutive cycles with no gaps.
- Reset mid-read: p0 read granted at cycle T; rst=0 at the T+1 edge -> p0_rvalid stays 0; p1_wait_cnt = 0 after reset.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: fixed-priority two-port data memory arbiter with bounded wait for port 1
module dm_arbiter #(
  parameter int ADDR_BITS = 10,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p0_req,
  input  logic                 p0_we,
  input  logic [31:0]          p0_addr,
  input  logic [31:0]          p0_wdata,
  output logic                 p0_gnt,
  output logic                 p0_rvalid,
  output logic [31:0]          p0_rdata,
  input  logic                 p1_req,
  input  logic                 p1_we,
  input  logic [31:0]          p1_addr,
  input  logic [31:0]          p1_wdata,
  output logic                 p1_gnt,
  output logic                 p1_rvalid,
  output logic [31:0]          p1_rdata,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 mem_we,
  input  logic [31:0]          mem_rdata,
  output logic [3:0]           p1_wait_cnt
);
  logic force1, rd_pending, rd_owner;
  always_comb begin
    force1    = p1_req && (p1_wait_cnt >= 4'(MAX_WAIT));
    p0_gnt    = rst && p0_req && !force1;
    p1_gnt    = rst && p1_req && (force1 || !p0_req);
    mem_addr  = p0_gnt ? p0_addr[ADDR_BITS-1:0] : p1_gnt ? p1_addr[ADDR_BITS-1:0] : '0;
    mem_wdata = p0_gnt ? p0_wdata : p1_gnt ? p1_wdata : '0;
    mem_we    = (p0_gnt && p0_we) || (p1_gnt && p1_we);
    p0_rvalid = rd_pending && !rd_owner;
    p1_rvalid = rd_pending && rd_owner;
    p0_rdata  = mem_rdata;
    p1_rdata  = mem_rdata;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      p1_wait_cnt <= '0;
      rd_pending  <= 1'b0;
      rd_owner    <= 1'b0;
    end else begin
      p1_wait_cnt <= (p1_req && !p1_gnt) ? ((p1_wait_cnt == 4'hf) ? 4'hf : p1_wait_cnt + 4'd1) : 4'd0;
      rd_pending  <= (p0_gnt && !p0_we) || (p1_gnt && !p1_we);
      rd_owner    <= p1_gnt;
    end
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed stimulus against a shadow-memory arbitration model
module tb_dm_arbiter;
  localparam int AW = 10;
  localparam int MW = 4;
  logic clk, rst;
  logic p0_req, p0_we, p0_gnt, p0_rvalid;
  logic p1_req, p1_we, p1_gnt, p1_rvalid;
  logic [31:0] p0_addr, p0_wdata, p0_rdata, p1_addr, p1_wdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic mem_we;
  logic [3:0] p1_wait_cnt;
  logic [31:0] mem [1024];
  int vectors = 0, errs = 0;
  logic [31:0] shadow [int];
  int m_wait = 0;
  bit armed = 0, ret_valid = 0, ret_port = 0;
  logic [31:0] ret_data = '0;

  dm_arbiter #(.ADDR_BITS(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .p1_wait_cnt(p1_wait_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Which port the rules say wins right now: -1 none, 0 or 1
  function automatic int who();
    if (!rst) return -1;
    if (p1_req && m_wait >= MW) return 1;
    if (p0_req) return 0;
    if (p1_req) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int w, a;
    logic we_w;
    if (!rst) begin
      m_wait = 0;
      ret_valid = 0;
      armed = 1;
    end else begin
      w = who();
      we_w = (w == 1) ? p1_we : p0_we;
      a = int'(((w == 1) ? p1_addr : p0_addr) % (1 << AW));
      ret_valid = (w >= 0) && !we_w;
      ret_port = (w == 1);
      ret_data = shadow.exists(a) ? shadow[a] : 'x;
      if (w >= 0 && we_w) shadow[a] = (w == 1) ? p1_wdata : p0_wdata;
      m_wait = (p1_req && w != 1) ? ((m_wait >= 15) ? 15 : m_wait + 1) : 0;
    end
  end

  always @(negedge clk) begin
    int w;
    if (armed) begin
      w = who();
      chk("p0_gnt", 32'(p0_gnt), 32'(w == 0));
      chk("p1_gnt", 32'(p1_gnt), 32'(w == 1));
      chk("mem_we", 32'(mem_we), 32'((w == 0 && p0_we) || (w == 1 && p1_we)));
      chk("mem_addr", 32'(mem_addr), (w < 0) ? 0 : ((w == 1) ? p1_addr : p0_addr) % (1 << AW));
      chk("mem_wdata", mem_wdata, (w < 0) ? 0 : (w == 1) ? p1_wdata : p0_wdata);
      chk("p1_wait_cnt", 32'(p1_wait_cnt), 32'(m_wait));
      chk("p0_rvalid", 32'(p0_rvalid), 32'(ret_valid && !ret_port));
      chk("p1_rvalid", 32'(p1_rvalid), 32'(ret_valid && ret_port));
      if (ret_valid) chk(ret_port ? "p1_rdata" : "p0_rdata", ret_port ? p1_rdata : p0_rdata, ret_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
  endtask

  task automatic p1_write(input logic [31:0] a, input logic [31:0] d);
    idle();
    p1_req = 1; p1_we = 1; p1_addr = a; p1_wdata = d;
    step();
    idle();
  endtask

  initial begin
    rst = 0;
    idle();
    p0_addr = 0; p0_wdata = 0; p1_addr = 0; p1_wdata = 0;
    step();
    step();
    mid();
    chk("rst_p0_gnt", 32'(p0_gnt), 0);
    chk("rst_p1_gnt", 32'(p1_gnt), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_rvalid", 32'({p0_rvalid, p1_rvalid}), 0);
    chk("rst_wait", 32'(p1_wait_cnt), 0);
    step();
    rst = 1;
    p1_write(5, 32'h2a);
    p1_write(1, 32'd11);
    p1_write(2, 32'd22);
    step();
    p0_req = 1; p0_we = 0; p0_addr = 5;
    mid();
    chk("single_gnt", 32'(p0_gnt), 1);
    step();
    idle();
    mid();
    chk("single_rvalid", 32'(p0_rvalid), 1);
    chk("single_rdata", p0_rdata, 32'h2a);
    chk("single_p1_rvalid", 32'(p1_rvalid), 0);
    step();
    p0_req = 1; p0_addr = 1; p1_req = 1; p1_addr = 2;
    for (int i = 0; i < 10; i++) begin
      mid();
      chk("starve_cnt", 32'(p1_wait_cnt), i % 5);
      chk("starve_p1_gnt", 32'(p1_gnt), 32'(i % 5 == 4));
      step();
    end
    idle();
    step();
    p1_req = 1; p1_we = 1; p1_addr = 32'h3ff; p1_wdata = 32'hdeadbeef;
    mid();
    chk("wr_mem_addr", 32'(mem_addr), 32'h3ff);
    step();
    idle();
    p0_req = 1; p0_addr = 32'h7ff;
    mid();
    chk("alias_mem_addr", 32'(mem_addr), 32'h3ff);
    step();
    idle();
    mid();
    chk("alias_rdata", p0_rdata, 32'hdeadbeef);
    step();
    p0_req = 1; p0_addr = 1;
    step();
    idle();
    p1_req = 1; p1_addr = 2;
    mid();
    chk("alt_p0_rvalid", 32'(p0_rvalid), 1);
    chk("alt_p0_rdata", p0_rdata, 32'd11);
    step();
    idle();
    mid();
    chk("alt_p1_rvalid", 32'(p1_rvalid), 1);
    chk("alt_p1_rdata", p1_rdata, 32'd22);
    step();
    p0_req = 1; p0_addr = 5; p1_req = 1; p1_addr = 1;
    mid();
    chk("rstmid_gnt", 32'(p0_gnt), 1);
    rst = 0;
    step();
    idle();
    mid();
    chk("rstmid_rvalid", 32'(p0_rvalid), 0);
    chk("rstmid_wait", 32'(p1_wait_cnt), 0);
    step();
    rst = 1;
    p1_req = 1; p1_addr = 5;
    mid();
    chk("p1_alone_gnt", 32'(p1_gnt), 1);
    step();
    idle();
    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
